// File: rtl/bpsk_frame_deframer.sv
// BPSK frame deframer: recovers symbol timing from the demodulator's hard-decision
// samples, slices bits by majority vote, hunts the sync word in either polarity and emits payload bytes.
`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 80
`endif

module bpsk_frame_deframer #(
    parameter int          SAMPLES_PER_SYMBOL = `SAMPLES_PER_SYMBOL,
    parameter logic [15:0] SYNC_WORD          = 16'hD391
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic       sym_bit,
    output logic       sym_valid,
    output logic       sync_locked,
    output logic       inverted,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end
);
    localparam int SPS   = SAMPLES_PER_SYMBOL;
    localparam int PH_W  = $clog2(SPS);
    localparam int CNT_W = $clog2(SPS + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SPS - 1);
    localparam logic [CNT_W:0]   HALF    = (CNT_W + 1)'(SPS / 2);

    typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_PAYLOAD} state_t;

    state_t           r_state, w_next;
    logic [PH_W-1:0]  r_ph, w_ph;
    logic [CNT_W-1:0] r_ones, w_ones;
    logic             r_prev;
    logic [15:0]      r_shift, w_shift;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_acc, w_acc;
    logic [7:0]       r_remaining;
    logic             r_first;
    logic             r_inverted;
    logic             w_realign, w_decide, w_raw, w_corr, w_last_byte;

    // Majority slice over a full window; an exact tie resolves to 0.
    function automatic logic slice_bit(input logic [CNT_W:0] sum);
        return sum > HALF;
    endfunction

    always_comb begin
        w_realign   = (r_state == ST_HUNT) && (data_in != r_prev);
        w_ph        = w_realign ? '0 : r_ph;
        w_ones      = w_realign ? '0 : r_ones;
        w_decide    = (w_ph == PH_LAST);
        w_raw       = slice_bit({1'b0, w_ones} + (CNT_W + 1)'(data_in));
        w_corr      = w_raw ^ r_inverted;
        w_shift     = {r_shift[14:0], w_raw};
        w_acc       = {r_acc[6:0], w_corr};
        w_last_byte = w_decide && (r_state == ST_PAYLOAD) && (r_bitcnt == 3'd7)
                      && (r_remaining == 8'd1);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_decide && (w_shift == SYNC_WORD || w_shift == ~SYNC_WORD))
                    w_next = ST_LEN;
            end
            ST_LEN: begin
                if (w_decide && r_bitcnt == 3'd7)
                    w_next = (w_acc == 8'd0) ? ST_HUNT : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (w_last_byte)
                    w_next = ST_HUNT;
            end
            default: w_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_HUNT;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph        <= '0;
            r_ones      <= '0;
            r_prev      <= 1'b0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_acc       <= '0;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_inverted  <= 1'b0;
            sym_bit     <= 1'b0;
            sym_valid   <= 1'b0;
            sync_locked <= 1'b0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            r_prev      <= data_in;
            sym_valid   <= 1'b0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            // Lock is held through the frame_end cycle and released on the next one.
            sync_locked <= (w_next != ST_HUNT) || w_last_byte;

            if (w_decide) begin
                r_ph      <= '0;
                r_ones    <= '0;
                sym_valid <= 1'b1;
                sym_bit   <= (r_state == ST_HUNT) ? w_raw : w_corr;
            end else begin
                r_ph   <= w_ph + PH_W'(1);
                r_ones <= w_ones + CNT_W'(data_in);
            end

            if (w_decide) begin
                case (r_state)
                    ST_HUNT: begin
                        r_shift <= w_shift;
                        if (w_shift == SYNC_WORD || w_shift == ~SYNC_WORD) begin
                            r_inverted <= (w_shift != SYNC_WORD);
                            r_bitcnt   <= '0;
                        end
                    end
                    ST_LEN: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_acc    <= w_acc;
                        if (r_bitcnt == 3'd7) begin
                            r_remaining <= w_acc;
                            r_first     <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_acc    <= w_acc;
                        if (r_bitcnt == 3'd7) begin
                            byte_out    <= w_acc;
                            byte_valid  <= 1'b1;
                            frame_start <= r_first;
                            frame_end   <= (r_remaining == 8'd1);
                            r_first     <= 1'b0;
                            r_remaining <= r_remaining - 8'd1;
                            if (r_remaining == 8'd1)
                                r_shift <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign inverted = r_inverted;

endmodule
